// File: rtl/rvfpm_xif_arbiter_pkg.sv
// Shared types and defaults for the two-hart rvfpm XIF arbiter.
package pa_rvfpm_arb;

    localparam int NUM_REQ             = 2;
    localparam int DEF_X_ID_WIDTH      = 4;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_CNT_W           = $clog2(DEF_MAX_OUTSTANDING + 1);

    // Outstanding-instruction counter for the default configuration
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // One queued commit: which hart, its own ID, and the kill flag
    typedef struct packed {
        logic                      req;
        logic [DEF_X_ID_WIDTH-1:0] id;
        logic                      kill;
    } commit_entry_t;

    // Two-way round-robin pick: a lone eligible hart wins, a tie goes to ptr.
    // With nobody eligible the result is 0 and the caller drops valid.
    function automatic logic rr_pick(input logic [1:0] elig, input logic ptr);
        return (elig == 2'b11) ? ptr : (elig == 2'b10);
    endfunction

endpackage

// File: rtl/rvfpm_commit_fifo.sv
// Commit queue: up to two pushes (port 0 ahead of port 1) and one pop per cycle.
module rvfpm_commit_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 8
)(
    input  logic         ck,
    input  logic         rst,
    input  logic         push0,
    input  logic [W-1:0] din0,
    input  logic         push1,
    input  logic [W-1:0] din1,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, wp1, rp;
    logic [CW-1:0] count, n_push;
    logic          do_pop;

    // Pointer advance with wrap, so DEPTH need not be a power of two
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign wp1    = ptr_inc(wp);
    assign n_push = CW'(push0) + CW'(push1);
    assign do_pop = pop && !empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rp];

    // Storage: when only port 1 pushes it takes the slot port 0 would have used
    always_ff @(posedge ck) begin
        if (push0) mem[wp] <= din0;
        if (push1) mem[push0 ? wp1 : wp] <= din1;
    end

    // Pointers and occupancy
    always_ff @(posedge ck) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            assert (int'(count) + int'(n_push) - int'(do_pop) <= DEPTH);
            if (push0 && push1)     wp <= ptr_inc(wp1);
            else if (push0 || push1) wp <= wp1;
            if (do_pop) rp <= ptr_inc(rp);
            count <= count + n_push - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rvfpm_xif_arbiter.sv
// Shares one rvfpm coprocessor between two CORE-V-XIF harts: round-robin
// issue with a hart tag in the ID MSB, serialised commits, results routed by tag.
module rvfpm_xif_arbiter
    import pa_rvfpm_arb::*;
#(
    parameter int X_ID_WIDTH      = DEF_X_ID_WIDTH,
    parameter int FLEN            = 32,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int COMMIT_DEPTH    = 2 * MAX_OUTSTANDING
)(
    input  logic                                 ck,
    input  logic                                 rst,
    input  logic [1:0]                           req_issue_valid,
    output logic [1:0]                           req_issue_ready,
    input  logic [1:0][31:0]                     req_issue_instr,
    input  logic [1:0][X_ID_WIDTH-1:0]           req_issue_id,
    input  logic [1:0][2:0][FLEN-1:0]            req_issue_rs,
    output logic [1:0]                           req_issue_accept,
    input  logic [1:0]                           req_commit_valid,
    input  logic [1:0][X_ID_WIDTH-1:0]           req_commit_id,
    input  logic [1:0]                           req_commit_kill,
    output logic [1:0]                           req_result_valid,
    input  logic [1:0]                           req_result_ready,
    output logic [X_ID_WIDTH-1:0]                req_result_id,
    output logic [FLEN-1:0]                      req_result_data,
    output logic [4:0]                           req_result_rd,
    output logic                                 req_result_we,
    output logic                                 fpu_issue_valid,
    input  logic                                 fpu_issue_ready,
    output logic [31:0]                          fpu_issue_instr,
    output logic [X_ID_WIDTH:0]                  fpu_issue_id,
    output logic [2:0][FLEN-1:0]                 fpu_issue_rs,
    input  logic                                 fpu_issue_accept,
    output logic                                 fpu_commit_valid,
    output logic [X_ID_WIDTH:0]                  fpu_commit_id,
    output logic                                 fpu_commit_kill,
    input  logic                                 fpu_result_valid,
    output logic                                 fpu_result_ready,
    input  logic [X_ID_WIDTH:0]                  fpu_result_id,
    input  logic [FLEN-1:0]                      fpu_result_data,
    input  logic [4:0]                           fpu_result_rd,
    input  logic                                 fpu_result_we
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW = X_ID_WIDTH + 2;   // {req, id, kill}

    logic                        rr_ptr, lock, g_q, g, iss_v;
    logic                        issue_hs, result_hs, sel;
    logic [NUM_REQ-1:0]          elig;
    logic [NUM_REQ-1:0][CW-1:0]  cnt, cnt_nxt;
    logic [EW-1:0]               head;
    logic                        cf_empty, cf_full, pop;

    // A hart competes only while it has room for another outstanding instruction
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_issue_valid[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
    end

    // Grant: held while a stalled request is pending so the FPU sees a stable offer
    always_comb begin
        if (lock) begin
            g     = g_q;
            iss_v = req_issue_valid[g_q];
        end else begin
            g     = rr_pick(elig, rr_ptr);
            iss_v = |elig;
        end
    end

    assign fpu_issue_valid = rst && iss_v;
    assign fpu_issue_instr = req_issue_instr[g];
    assign fpu_issue_id    = {g, req_issue_id[g]};
    assign fpu_issue_rs    = req_issue_rs[g];
    assign issue_hs        = fpu_issue_valid && fpu_issue_ready;

    assign sel              = fpu_result_id[X_ID_WIDTH];
    assign fpu_result_ready = rst && req_result_ready[sel];
    assign result_hs        = fpu_result_valid && fpu_result_ready;
    assign req_result_id    = fpu_result_id[X_ID_WIDTH-1:0];
    assign req_result_data  = fpu_result_data;
    assign req_result_rd    = fpu_result_rd;
    assign req_result_we    = fpu_result_we;

    // Per-hart handshake fan-out; ready/accept only reach the granted hart and
    // only while an offer is live, so a throttled hart never sees a handshake
    always_comb begin
        req_issue_ready       = '0;
        req_issue_accept      = '0;
        req_result_valid      = '0;
        req_issue_ready[g]    = issue_hs;
        req_issue_accept[g]   = fpu_issue_valid && fpu_issue_accept;
        req_result_valid[sel] = rst && fpu_result_valid;
    end

    // Commit serialisation: hart 0 queued ahead of hart 1, one pop per cycle
    assign pop = rst && !cf_empty;

    rvfpm_commit_fifo #(
        .W     (EW),
        .DEPTH (COMMIT_DEPTH)
    ) u_commit_fifo (
        .ck    (ck),
        .rst   (rst),
        .push0 (rst && req_commit_valid[0]),
        .din0  ({1'b0, req_commit_id[0], req_commit_kill[0]}),
        .push1 (rst && req_commit_valid[1]),
        .din1  ({1'b1, req_commit_id[1], req_commit_kill[1]}),
        .pop   (pop),
        .dout  (head),
        .full  (cf_full),
        .empty (cf_empty)
    );

    assign fpu_commit_valid = pop;
    assign fpu_commit_id    = head[EW-1:1];
    assign fpu_commit_kill  = head[0];

    // Outstanding counters: +1 on accepted issue, -1 on killed commit pop, -1 on result
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic          inc, dec_k, dec_r;
        logic [CW:0]   nxt;

        assign inc   = issue_hs && fpu_issue_accept && (g == 1'(i));
        assign dec_k = pop && head[0] && (head[EW-1] == 1'(i));
        assign dec_r = result_hs && (sel == 1'(i));
        assign nxt   = {1'b0, cnt[i]} + {{CW{1'b0}}, inc}
                     - {{CW{1'b0}}, dec_k} - {{CW{1'b0}}, dec_r};
        assign cnt_nxt[i] = nxt[CW-1:0];

        // A borrow out of the counter means more retirements than acceptances
        always_ff @(posedge ck) begin
            if (rst) assert (!nxt[CW]);
        end
    end

    // A full queue still frees one slot by popping, but cannot absorb two pushes
    always_ff @(posedge ck) begin
        if (rst) assert (!(cf_full && (&req_commit_valid)));
    end

    // Arbitration state and counters
    always_ff @(posedge ck) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
            lock   <= 1'b0;
            g_q    <= 1'b0;
            cnt    <= '0;
        end else begin
            g_q  <= g;
            lock <= fpu_issue_valid && !fpu_issue_ready;
            if (issue_hs) rr_ptr <= ~g;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rvfpm_xif_arbiter.sv
// Directed + randomized bench for rvfpm_xif_arbiter against a transaction-level model.
module tb_rvfpm_xif_arbiter;
    localparam int XW = 4;
    localparam int FL = 32;
    localparam int MO = 4;

    logic                       ck = 1'b0;
    logic                       rst;
    logic [1:0]                 req_issue_valid, req_issue_ready, req_issue_accept;
    logic [1:0][31:0]           req_issue_instr;
    logic [1:0][XW-1:0]         req_issue_id;
    logic [1:0][2:0][FL-1:0]    req_issue_rs;
    logic [1:0]                 req_commit_valid, req_commit_kill;
    logic [1:0][XW-1:0]         req_commit_id;
    logic [1:0]                 req_result_valid, req_result_ready;
    logic [XW-1:0]              req_result_id;
    logic [FL-1:0]              req_result_data;
    logic [4:0]                 req_result_rd;
    logic                       req_result_we;
    logic                       fpu_issue_valid, fpu_issue_ready, fpu_issue_accept;
    logic [31:0]                fpu_issue_instr;
    logic [XW:0]                fpu_issue_id;
    logic [2:0][FL-1:0]         fpu_issue_rs;
    logic                       fpu_commit_valid, fpu_commit_kill;
    logic [XW:0]                fpu_commit_id;
    logic                       fpu_result_valid, fpu_result_ready, fpu_result_we;
    logic [XW:0]                fpu_result_id;
    logic [FL-1:0]              fpu_result_data;
    logic [4:0]                 fpu_result_rd;

    rvfpm_xif_arbiter #(.X_ID_WIDTH(XW), .FLEN(FL), .MAX_OUTSTANDING(MO)) dut (
        .ck(ck), .rst(rst),
        .req_issue_valid(req_issue_valid), .req_issue_ready(req_issue_ready),
        .req_issue_instr(req_issue_instr), .req_issue_id(req_issue_id),
        .req_issue_rs(req_issue_rs), .req_issue_accept(req_issue_accept),
        .req_commit_valid(req_commit_valid), .req_commit_id(req_commit_id),
        .req_commit_kill(req_commit_kill),
        .req_result_valid(req_result_valid), .req_result_ready(req_result_ready),
        .req_result_id(req_result_id), .req_result_data(req_result_data),
        .req_result_rd(req_result_rd), .req_result_we(req_result_we),
        .fpu_issue_valid(fpu_issue_valid), .fpu_issue_ready(fpu_issue_ready),
        .fpu_issue_instr(fpu_issue_instr), .fpu_issue_id(fpu_issue_id),
        .fpu_issue_rs(fpu_issue_rs), .fpu_issue_accept(fpu_issue_accept),
        .fpu_commit_valid(fpu_commit_valid), .fpu_commit_id(fpu_commit_id),
        .fpu_commit_kill(fpu_commit_kill),
        .fpu_result_valid(fpu_result_valid), .fpu_result_ready(fpu_result_ready),
        .fpu_result_id(fpu_result_id), .fpu_result_data(fpu_result_data),
        .fpu_result_rd(fpu_result_rd), .fpu_result_we(fpu_result_we)
    );

    always #5 ck = ~ck;

    // Reference model: per-hart outstanding tallies, a queue of commits,
    // the hart that gets the next tie, and a stalled offer that must be repeated
    typedef struct packed { logic r; logic [XW-1:0] id; logic k; } ce_t;
    ce_t m_q[$];
    int  m_cnt[2];
    int  m_tie;
    int  m_stalled;            // -1: no offer waiting on the FPU
    bit  last_hs[2], last_acc[2], last_res_hs;
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs against the model, then advance the model across the edge
    task automatic step();
        int        g, s;
        bit        fv;
        bit [1:0]  el;
        ce_t       h;
        #1;
        last_hs = '{0, 0}; last_acc = '{0, 0}; last_res_hs = 0;
        if (!rst) begin
            chk("rst_issue_valid",  128'(fpu_issue_valid),  '0);
            chk("rst_issue_ready",  128'(req_issue_ready),  '0);
            chk("rst_issue_accept", 128'(req_issue_accept), '0);
            chk("rst_commit_valid", 128'(fpu_commit_valid), '0);
            chk("rst_result_valid", 128'(req_result_valid), '0);
            chk("rst_result_ready", 128'(fpu_result_ready), '0);
            m_cnt = '{0, 0}; m_tie = 0; m_stalled = -1; m_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) el[i] = req_issue_valid[i] && (m_cnt[i] < MO);
            if (m_stalled >= 0) begin
                g  = m_stalled;
                fv = req_issue_valid[g];
            end else begin
                fv = |el;
                if (el[0] && el[1]) g = m_tie;
                else                g = el[1] ? 1 : 0;
            end
            chk("issue_valid", 128'(fpu_issue_valid), 128'(fv));
            chk("issue_ready", 128'(req_issue_ready),
                (fv && fpu_issue_ready) ? 128'(1) << g : '0);
            chk("issue_accept", 128'(req_issue_accept),
                (fv && fpu_issue_accept) ? 128'(1) << g : '0);
            if (fv) begin
                chk("issue_id",    128'(fpu_issue_id),    128'({g[0], req_issue_id[g]}));
                chk("issue_instr", 128'(fpu_issue_instr), 128'(req_issue_instr[g]));
                chk("issue_rs",    128'(fpu_issue_rs),    128'(req_issue_rs[g]));
            end
            chk("commit_valid", 128'(fpu_commit_valid), 128'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                h = m_q[0];
                chk("commit_id",   128'(fpu_commit_id),   128'({h.r, h.id}));
                chk("commit_kill", 128'(fpu_commit_kill), 128'(h.k));
            end
            s = int'(fpu_result_id[XW]);
            chk("result_valid", 128'(req_result_valid),
                fpu_result_valid ? 128'(1) << s : '0);
            chk("result_ready", 128'(fpu_result_ready), 128'(req_result_ready[s]));
            if (fpu_result_valid) begin
                chk("result_id",   128'(req_result_id),   128'(fpu_result_id[XW-1:0]));
                chk("result_data", 128'(req_result_data), 128'(fpu_result_data));
                chk("result_rdwe", 128'({req_result_rd, req_result_we}),
                    128'({fpu_result_rd, fpu_result_we}));
            end
            // edge effects
            if (fv && fpu_issue_ready) begin
                m_tie = 1 - g;
                m_stalled = -1;
                last_hs[g] = 1;
                if (fpu_issue_accept) begin m_cnt[g]++; last_acc[g] = 1; end
            end else m_stalled = fv ? g : -1;
            if (m_q.size() != 0) begin
                h = m_q.pop_front();
                if (h.k) m_cnt[int'(h.r)]--;
            end
            if (fpu_result_valid && req_result_ready[s]) begin
                m_cnt[s]--;
                last_res_hs = 1;
            end
            for (int i = 0; i < 2; i++)
                if (req_commit_valid[i]) m_q.push_back('{1'(i), req_commit_id[i], req_commit_kill[i]});
        end
        @(negedge ck);
    endtask

    task automatic new_instr(input int i);
        req_issue_id[i]    = XW'($urandom);
        req_issue_instr[i] = $urandom;
        req_issue_rs[i]    = {$urandom, $urandom, $urandom};
    endtask

    int  unc[2], resq[2];
    int  rsel;

    initial begin
        rst = 1'b0;
        req_issue_valid = '0; req_issue_instr = '0; req_issue_id = '0; req_issue_rs = '0;
        req_commit_valid = '0; req_commit_id = '0; req_commit_kill = '0;
        req_result_ready = '0;
        fpu_issue_ready = 1'b0; fpu_issue_accept = 1'b0;
        fpu_result_valid = 1'b0; fpu_result_id = '0; fpu_result_data = '0;
        fpu_result_rd = '0; fpu_result_we = 1'b0;
        m_stalled = -1;
        @(negedge ck);

        // reset with everything asserted: outputs must stay low
        req_issue_valid = 2'b11; fpu_issue_ready = 1; fpu_issue_accept = 1;
        fpu_result_valid = 1; req_result_ready = 2'b11;
        step(); step();

        // both harts hammering: grants alternate 0,1,0,1,0,1
        rst = 1; fpu_result_valid = 0;
        for (int k = 0; k < 6; k++) begin new_instr(0); new_instr(1); step(); end
        req_issue_valid = 2'b00;

        // simultaneous commits: {0,3,0} then {1,5,1}
        req_commit_valid = 2'b11; req_commit_id[0] = 4'd3; req_commit_id[1] = 4'd5;
        req_commit_kill = 2'b10;
        step();
        req_commit_valid = 2'b00; req_commit_kill = 2'b00;
        step(); step();

        // result for hart 1 held off by its ready for two cycles
        fpu_result_valid = 1; fpu_result_id = 5'b1_0010; fpu_result_data = $urandom;
        fpu_result_rd = 5'd7; fpu_result_we = 1; req_result_ready = 2'b01;
        step(); step();
        req_result_ready = 2'b10;
        step();
        fpu_result_valid = 0;

        // stalled offer from hart 0 holds while hart 1 joins
        fpu_issue_ready = 0; req_issue_valid = 2'b01; new_instr(0);
        step();
        req_issue_valid = 2'b11; new_instr(1);
        step(); step();
        fpu_issue_ready = 1;
        step(); step();
        req_issue_valid = 2'b00;

        // free one slot for hart 0, then fill hart 1 to its limit
        fpu_result_valid = 1; fpu_result_id = 5'b0_0001; req_result_ready = 2'b11;
        step();
        fpu_result_valid = 0; req_issue_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin new_instr(1); step(); end
        req_issue_valid = 2'b11; new_instr(0);
        step();
        req_issue_valid = 2'b10;
        fpu_result_valid = 1; fpu_result_id = 5'b1_0100;
        step();
        fpu_result_valid = 0;
        step();
        req_issue_valid = 2'b00;

        // reset mid-traffic with the commit queue occupied
        req_commit_valid = 2'b11; req_commit_kill = 2'b00;
        step();
        req_commit_valid = 2'b00; rst = 0;
        step();
        rst = 1; req_issue_valid = 2'b11; fpu_issue_ready = 0;
        step();
        fpu_issue_ready = 1; req_issue_valid = 2'b00;
        step();

        // randomized traffic; commits and results only for instructions the model accepted
        unc = '{0, 0}; resq = '{0, 0};
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++)
                if (!req_issue_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_issue_valid[i] = 1; new_instr(i);
                end
            fpu_issue_ready  = ($urandom_range(0, 3) != 0);
            fpu_issue_accept = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                req_commit_valid[i] = (unc[i] > 0) && ($urandom_range(0, 2) == 0);
                req_commit_kill[i]  = ($urandom_range(0, 3) == 0);
                req_commit_id[i]    = XW'($urandom);
            end
            if (!fpu_result_valid && (resq[0] + resq[1] > 0) && $urandom_range(0, 1) == 1) begin
                rsel = (resq[0] == 0) ? 1 : (resq[1] == 0) ? 0 : int'($urandom_range(0, 1));
                fpu_result_valid = 1;
                fpu_result_id    = {rsel[0], XW'($urandom)};
                fpu_result_data  = $urandom;
                fpu_result_rd    = 5'($urandom);
                fpu_result_we    = 1'($urandom);
            end
            req_result_ready = 2'($urandom);
            step();
            for (int i = 0; i < 2; i++) begin
                if (last_hs[i]) begin
                    req_issue_valid[i] = 0;
                    if (last_acc[i]) unc[i]++;
                end
                if (req_commit_valid[i]) begin
                    unc[i]--;
                    if (!req_commit_kill[i]) resq[i]++;
                end
            end
            if (last_res_hs) begin
                resq[int'(fpu_result_id[XW])]--;
                fpu_result_valid = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfpm_xif_arbiter.md
Name: rvfpm_xif_arbiter

Overview:
- Shares one rvfpm coprocessor between two CORE-V-XIF requesters (harts).
- Round-robin issue arbitration. Tags each instruction ID with the requester index. Serialises the two commit streams into the FPU's single commit port. Routes results back by tag.
- Sits between the cores' XIF ports and the rvfpm issue/commit/result interfaces.
- Throttles each requester to a bounded number of outstanding instructions.

Parameters:
- X_ID_WIDTH, 4: requester-side ID width. FPU-side ID is X_ID_WIDTH+1 bits; MSB = requester index.
- FLEN, 32: operand/result width.
- MAX_OUTSTANDING, 4: maximum accepted but unretired instructions per requester.
- COMMIT_DEPTH, 2*MAX_OUTSTANDING: commit FIFO entries.

Ports:
- ck  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_issue_valid  in  [1:0]  issue request per requester
- req_issue_ready  out  [1:0]  issue ready per requester
- req_issue_instr  in  [1:0][31:0]  instruction word
- req_issue_id  in  [1:0][X_ID_WIDTH-1:0]  requester instruction ID
- req_issue_rs  in  [1:0][2:0][FLEN-1:0]  source operands
- req_issue_accept  out  [1:0]  accept, returned to the granted requester only
- req_commit_valid  in  [1:0]  commit strobe
- req_commit_id  in  [1:0][X_ID_WIDTH-1:0]  committed ID
- req_commit_kill  in  [1:0]  kill flag
- req_result_valid  out  [1:0]  result valid, routed by tag
- req_result_ready  in  [1:0]  result ready
- req_result_id  out  X_ID_WIDTH  result ID, tag stripped
- req_result_data  out  FLEN  result data, shared
- req_result_rd  out  5  destination register
- req_result_we  out  1  write enable
- fpu_issue_valid  out  1  to rvfpm issue_valid
- fpu_issue_ready  in  1  from rvfpm issue_ready
- fpu_issue_instr  out  32  instruction to rvfpm
- fpu_issue_id  out  X_ID_WIDTH+1  tagged ID
- fpu_issue_rs  out  [2:0][FLEN-1:0]  operands to rvfpm
- fpu_issue_accept  in  1  from rvfpm issue_resp.accept
- fpu_commit_valid  out  1  to rvfpm commit_valid
- fpu_commit_id  out  X_ID_WIDTH+1  tagged commit ID
- fpu_commit_kill  out  1  kill flag to rvfpm
- fpu_result_valid  in  1  from rvfpm result_valid
- fpu_result_ready  out  1  to rvfpm result_ready
- fpu_result_id  in  X_ID_WIDTH+1  tagged result ID
- fpu_result_data  in  FLEN  result data
- fpu_result_rd  in  5  destination register
- fpu_result_we  in  1  write enable

Behaviour:
- Reset: one clock, ck. rst is synchronous and active-low. On a ck edge with rst=0:
  - rr_ptr=0, lock=0, both outstanding counters=0, commit FIFO empty.
  - While rst=0, every valid/ready/accept output is forced to 0.
- Eligibility: requester i is eligible when req_issue_valid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Grant (combinational) when lock=0:
  - Only one requester eligible: grant it.
  - Both eligible: grant rr_ptr.
  - Neither eligible: fpu_issue_valid=0.
- Grant when lock=1: hold the registered grant g_q.
- lock is set at an edge where fpu_issue_valid=1 and fpu_issue_ready=0, and cleared on the handshake edge. This keeps the FPU-side request stable (XIF rule).
- Issue path (combinational):
  - fpu_issue_instr/rs come from the granted requester; fpu_issue_id = {g, req_issue_id[g]}.
  - req_issue_ready[g] = fpu_issue_ready; req_issue_accept[g] = fpu_issue_accept; the other requester sees 0 on both.
- Issue handshake edge (fpu_issue_valid & fpu_issue_ready): rr_ptr <= ~g. If accept=1, cnt[g] increments.
- Commit path:
  - Each cycle, valid commits are pushed into the FIFO as {i, id, kill}; requester 0 first, then 1, so two pushes are allowed per cycle.
  - Head pops one per cycle onto fpu_commit_*, giving latency 1 cycle minimum.
  - The FIFO never overflows because commits ≤ outstanding ≤ 2*MAX_OUTSTANDING. An overflow push is an assertion failure.
  - A killed commit popped for requester i decrements cnt[i].
- Result path (combinational):
  - sel = fpu_result_id MSB. req_result_valid[sel] = fpu_result_valid; the other requester sees 0.
  - fpu_result_ready = req_result_ready[sel].
  - req_result_id/data/rd/we are passed through, with the tag stripped from the ID.
- Result handshake edge: cnt[sel] decrements. Every accepted, non-killed instruction yields exactly one result.
- Counter rules: increment and decrement of the same counter in one cycle leaves it unchanged. Two decrements in one cycle (kill pop plus result) subtract 2. Underflow is an assertion failure.
- Reset mid-operation: all state is cleared. In-flight FPU instructions are the system's responsibility; the rvfpm is reset together with this block.

Decomposition:
- Package pa_rvfpm_arb:
  - typedef commit_entry_t {logic req; logic [X_ID_WIDTH-1:0] id; logic kill;}
  - typedef cnt_t sized $clog2(MAX_OUTSTANDING+1).
  - localparam NUM_REQ = 2.
- Sub-module rvfpm_commit_fifo: 2-write/1-read synchronous FIFO, depth COMMIT_DEPTH, with full/empty flags and the overflow assertion.

Test Plan:
- Both valid every cycle, FPU always ready/accept, 6 issues → grants alternate 0,1,0,1,0,1; fpu_issue_id MSB alternates; each counter reaches 3.
- Requester 0 valid, fpu_issue_ready low 3 cycles, requester 1 raises valid in cycle 2 → grant stays 0 and instr/id are stable until the handshake; requester 1 is granted next.
- Requester 1 issues 4 accepted instructions with no results (MAX_OUTSTANDING=4) → req_issue_ready[1]=0; requester 0 still issues. One result for req 1 → requester 1 is eligible again the next cycle.
- Both commit in the same cycle (ids 3 and 5, kill=0/1) → fpu_commit carries {0,3,0} at cycle +1 and {1,5,1} at cycle +2; cnt[1] decrements at the second pop.
- fpu_result_id=5'b1_0010 valid, req_result_ready[1]=0 for 2 cycles → fpu_result_ready=0 and req_result_valid=2'b10 with id=2 held; cnt[1] decrements only on the handshake.
- rst=0 for one edge mid-traffic with a non-empty FIFO → next cycle counters are 0, FIFO is empty, rr_ptr=0, all outputs low during reset.
